// File: rtl/regfile_writeback_queue_if.sv
// Bundles the producer handshakes, register-file write port and snoop port
// of the write-back queue. The master side is the pipeline, the slave side the queue.
interface regfile_writeback_queue_if #(
    parameter int N     = 64,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             mem_valid;
    logic [4:0]       mem_da;
    logic [N-1:0]     mem_d;
    logic             mem_ready;

    logic             alu_valid;
    logic [4:0]       alu_da;
    logic [N-1:0]     alu_d;
    logic             alu_ready;

    logic [N-1:0]     D;
    logic [4:0]       DA;
    logic             W;

    logic [4:0]       fwd_sa;
    logic             fwd_hit;
    logic [N-1:0]     fwd_d;

    logic [CNT_W-1:0] count;

    modport master (
        output mem_valid, mem_da, mem_d,
        output alu_valid, alu_da, alu_d,
        output fwd_sa,
        input  mem_ready, alu_ready,
        input  D, DA, W,
        input  fwd_hit, fwd_d,
        input  count
    );

    modport slave (
        input  mem_valid, mem_da, mem_d,
        input  alu_valid, alu_da, alu_d,
        input  fwd_sa,
        output mem_ready, alu_ready,
        output D, DA, W,
        output fwd_hit, fwd_d,
        output count
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Write-back stage: merges ALU and memory results into an in-order queue and
// issues one register-file write per clock, with a newest-wins snoop for forwarding.
module regfile_writeback_queue #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    regfile_writeback_queue_if.slave    bus
);
    localparam int         PTR_W = $clog2(DEPTH);
    localparam int         CNT_W = PTR_W + 1;
    localparam logic [4:0] XZR   = 5'd31;

    typedef struct packed {
        logic [4:0]   da;
        logic [N-1:0] d;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    entry_t             fifo_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               w_q, w_d;
    logic [4:0]         da_q, da_d;
    logic [N-1:0]       d_q, d_d;

    logic               mem_rdy, alu_rdy;
    logic               mem_keep, alu_keep;
    logic [1:0]         n_new;
    entry_t             mem_e, alu_e, new0, new1;

    logic               hit;
    logic [N-1:0]       hit_d;
    logic [PTR_W-1:0]   snoop_idx;

    // The ALU's slot budget already accounts for a memory result offered this cycle.
    assign mem_rdy = count_q < CNT_W'(DEPTH);
    assign alu_rdy = (count_q + CNT_W'(bus.mem_valid)) < CNT_W'(DEPTH);

    // NOTE: every variable written below gets a default first, so no path can infer a latch.
    always_comb begin
        mem_keep = bus.mem_valid && mem_rdy && (bus.mem_da != XZR);
        alu_keep = bus.alu_valid && alu_rdy && (bus.alu_da != XZR);
        mem_e    = '{da: bus.mem_da, d: bus.mem_d};
        alu_e    = '{da: bus.alu_da, d: bus.alu_d};
        new0     = mem_keep ? mem_e : alu_e;
        new1     = alu_e;
        n_new    = {1'b0, mem_keep} + {1'b0, alu_keep};

        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        w_d      = 1'b0;
        da_d     = da_q;
        d_d      = d_q;

        if (count_q != '0) begin
            // Queued entries are older than anything arriving now: head issues first.
            w_d      = 1'b1;
            da_d     = fifo_q[rd_ptr_q].da;
            d_d      = fifo_q[rd_ptr_q].d;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (n_new != 2'd0) fifo_d[wr_ptr_q] = new0;
            if (n_new == 2'd2) fifo_d[wr_ptr_q + PTR_W'(1)] = new1;
            wr_ptr_d = wr_ptr_q + PTR_W'(n_new);
            count_d  = count_q + CNT_W'(n_new) - CNT_W'(1);
        end else if (n_new != 2'd0) begin
            w_d  = 1'b1;
            da_d = new0.da;
            d_d  = new0.d;
            if (n_new == 2'd2) begin
                fifo_d[wr_ptr_q] = new1;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                count_d          = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            w_q      <= 1'b0;
            da_q     <= '0;
            d_q      <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            w_q      <= w_d;
            da_q     <= da_d;
            d_q      <= d_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count_q alone decides which slots are live.
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

    // Scan oldest to newest so the last match (newest) overrides earlier ones.
    always_comb begin
        hit       = 1'b0;
        hit_d     = '0;
        snoop_idx = rd_ptr_q;
        if (bus.fwd_sa != XZR) begin
            if (w_q && (da_q == bus.fwd_sa)) begin
                hit   = 1'b1;
                hit_d = d_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                snoop_idx = rd_ptr_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (fifo_q[snoop_idx].da == bus.fwd_sa)) begin
                    hit   = 1'b1;
                    hit_d = fifo_q[snoop_idx].d;
                end
            end
        end
    end

    assign bus.mem_ready = mem_rdy;
    assign bus.alu_ready = alu_rdy;
    assign bus.W         = w_q;
    assign bus.DA        = da_q;
    assign bus.D         = d_q;
    assign bus.count     = count_q;
    assign bus.fwd_hit   = hit;
    assign bus.fwd_d     = hit_d;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_regfile_writeback_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_writeback_queue_if bus ();
    regfile_writeback_queue dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic [4:0]  da;
        logic [63:0] d;
    } ent_t;

    // Reference state: pending writes (oldest first) and the register-file write port.
    ent_t        q[$];
    bit          m_w;
    logic [4:0]  m_da;
    logic [63:0] m_d;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_w  = 1'b0;
        m_da = '0;
        m_d  = '0;
    endtask

    // Newest pending write to sa; XZR never matches.
    task automatic model_fwd(input logic [4:0] sa, output bit hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (sa != 5'd31) begin
            for (int i = q.size() - 1; i >= 0 && !hit; i--) begin
                if (q[i].da == sa) begin
                    hit = 1'b1;
                    d   = q[i].d;
                end
            end
            if (!hit && m_w && (m_da == sa)) begin
                hit = 1'b1;
                d   = m_d;
            end
        end
    endtask

    // One clock of stimulus; entered and left at posedge + 1.
    task automatic step(input bit mv, input logic [4:0] mda, input logic [63:0] md,
                        input bit av, input logic [4:0] ada, input logic [63:0] ad,
                        input logic [4:0] sa);
        bit          exp_mr, exp_ar, exp_hit;
        logic [63:0] exp_fd;
        ent_t        cand[$];
        ent_t        head;
        bus.mem_valid = mv;
        bus.mem_da    = mda;
        bus.mem_d     = md;
        bus.alu_valid = av;
        bus.alu_da    = ada;
        bus.alu_d     = ad;
        bus.fwd_sa    = sa;
        #1;
        exp_mr = q.size() < 4;
        exp_ar = (q.size() + int'(mv)) < 4;
        model_fwd(sa, exp_hit, exp_fd);
        check("mem_ready", 64'(bus.mem_ready), 64'(exp_mr));
        check("alu_ready", 64'(bus.alu_ready), 64'(exp_ar));
        check("count_pre", 64'(bus.count), 64'(q.size()));
        check("fwd_hit", 64'(bus.fwd_hit), 64'(exp_hit));
        check("fwd_d", bus.fwd_d, exp_fd);
        @(posedge clock);
        cand = q;
        if (mv && exp_mr && mda != 5'd31) cand.push_back('{da: mda, d: md});
        if (av && exp_ar && ada != 5'd31) cand.push_back('{da: ada, d: ad});
        if (cand.size() > 0) begin
            head = cand.pop_front();
            m_w  = 1'b1;
            m_da = head.da;
            m_d  = head.d;
        end else begin
            m_w = 1'b0;
        end
        q = cand;
        #1;
        check("W", 64'(bus.W), 64'(m_w));
        check("DA", 64'(bus.DA), 64'(m_da));
        check("D", bus.D, m_d);
        check("count", 64'(bus.count), 64'(q.size()));
    endtask

    task automatic idle(input int n, input logic [4:0] sa);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, sa);
    endtask

    function automatic logic [4:0] rand_da();
        return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_valid = 1'b0; bus.mem_da = '0; bus.mem_d = '0;
        bus.alu_valid = 1'b0; bus.alu_da = '0; bus.alu_d = '0;
        bus.fwd_sa    = '0;
        model_reset();
        #13;
        check("rst_W", 64'(bus.W), 64'd0);
        check("rst_DA", 64'(bus.DA), 64'd0);
        check("rst_D", bus.D, 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single ALU write into an empty queue: one-cycle latency.
        step(0, 0, 0, 1, 5'd5, 64'h1234, 5'd5);
        check("alu5_W", 64'(bus.W), 64'd1);
        check("alu5_DA", 64'(bus.DA), 64'd5);
        check("alu5_D", bus.D, 64'h1234);
        idle(1, 5'd5);
        check("alu5_W_drop", 64'(bus.W), 64'd0);

        // Same destination from both producers: mem first, alu last.
        step(1, 5'd2, 64'hAA, 1, 5'd2, 64'hBB, 5'd2);
        check("same_da_first", bus.D, 64'hAA);
        check("same_da_fwd", bus.fwd_d, 64'hBB);
        idle(1, 5'd2);
        check("same_da_second", bus.D, 64'hBB);
        idle(1, 5'd2);

        // Both producers held valid: queue fills, readies throttle, order kept across wrap.
        for (int i = 0; i < 8; i++)
            step(1, 5'(i % 8), 64'(100 + 2 * i), 1, 5'((i + 3) % 8), 64'(101 + 2 * i), 5'(i % 8));
        idle(6, 5'd3);

        // Writes to XZR are swallowed and never forwarded.
        step(0, 0, 0, 1, 5'd31, 64'hDEAD, 5'd31);
        check("xzr_W", 64'(bus.W), 64'd0);
        check("xzr_count", 64'(bus.count), 64'd0);
        step(1, 5'd31, 64'h55, 1, 5'd4, 64'h66, 5'd31);
        idle(2, 5'd31);

        // Back-to-back writes to r7: the forward value tracks the newest.
        step(0, 0, 0, 1, 5'd7, 64'd1, 5'd7);
        step(0, 0, 0, 1, 5'd7, 64'd2, 5'd7);
        step(0, 0, 0, 1, 5'd7, 64'd3, 5'd7);
        idle(2, 5'd7);
        check("r7_fwd_gone", 64'(bus.fwd_hit), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rand_da(), {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), rand_da(), {$urandom, $urandom},
                 ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7)));
        end
        idle(6, 5'd0);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++)
            step(1, 5'(i + 1), 64'(200 + i), 1, 5'(i + 4), 64'(300 + i), 5'(i + 1));
        check("pre_rst_count", 64'(bus.count), 64'd3);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_W", 64'(bus.W), 64'd0);
        check("async_count", 64'(bus.count), 64'd0);
        check("async_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("async_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("async_fwd_hit", 64'(bus.fwd_hit), 64'd0);
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        idle(4, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
